issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 19 +
 rtl/issue_ctrl_pair_chk.sv | 32 +++
 rtl/issue_ctrl.sv | 108 ++++++++++
 tb/tb_issue_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Shared issue definitions: instruction class encoding and default load-use bubble depth.
package Public_Info;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_BR     = 3'd1,
        CLS_LD     = 3'd2,
        CLS_ST     = 3'd3,
        CLS_MULDIV = 3'd4,
        CLS_PRIV   = 3'd5
    } cls_e;

    localparam int LU_BUBBLE_DEF = 1;

    function automatic logic is_mem(input cls_e c);
        return (c == CLS_LD) || (c == CLS_ST);
    endfunction

endpackage

// File: rtl/issue_ctrl_pair_chk.sv
// Combinational check deciding whether slot B may issue alongside slot A.
module issue_pair_chk
    import Public_Info::*;
(
    input  logic       b_valid,
    input  logic [4:0] a_rd,
    input  logic       a_we,
    input  cls_e       a_cls,
    input  logic [4:0] b_raddr1,
    input  logic [4:0] b_raddr2,
    input  cls_e       b_cls,
    input  logic [4:0] ld_rd,
    input  logic       ld_pend,
    output logic       b_ok
);

    logic raw_ab;
    logic raw_ld;
    logic cls_conflict;

    assign raw_ab = a_we && (a_rd != 5'd0) && ((b_raddr1 == a_rd) || (b_raddr2 == a_rd));
    assign raw_ld = ld_pend && (ld_rd != 5'd0) && ((b_raddr1 == ld_rd) || (b_raddr2 == ld_rd));

    // Shared memory port and single MUL/DIV unit; control transfers and PRIV end the pair.
    assign cls_conflict = (is_mem(a_cls) && is_mem(b_cls))
                       || ((a_cls == CLS_MULDIV) && (b_cls == CLS_MULDIV))
                       || (a_cls == CLS_BR) || (a_cls == CLS_PRIV)
                       || (b_cls == CLS_PRIV);

    assign b_ok = b_valid && !raw_ab && !raw_ld && !cls_conflict;

endmodule

// File: rtl/issue_ctrl.sv
// Two-slot issue controller: load-use scoreboard, PRIV serialization FSM, pair issue.
// Define DUAL_ISSUE_EN to allow slot B to issue; otherwise at most one slot per cycle.
module issue_ctrl
    import Public_Info::*;
#(
    parameter int LU_BUBBLE = LU_BUBBLE_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_is_valid,
    input  logic [4:0] a_rf_raddr1,
    input  logic [4:0] a_rf_raddr2,
    input  logic [4:0] b_rf_raddr1,
    input  logic [4:0] b_rf_raddr2,
    input  logic [4:0] a_rf_rd,
    input  logic [4:0] b_rf_rd,
    input  logic       a_rf_we,
    input  logic       b_rf_we,
    input  logic [2:0] a_cls,
    input  logic [2:0] b_cls,
    input  logic       flush_BR,
    input  logic       stall_DCache,
    input  logic       stall_div,
    input  logic       i_serial_done,
    output logic [1:0] o_usingNUM,
    output logic       o_serial_busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SERIAL = 1'b1;

    logic [0:0] state;
    logic [4:0] ld_rd;
    logic [1:0] lu_cnt;
    logic       ld_pend;
    logic       stall;
    logic       blocked;
    logic       a_haz;
    logic       issue_a;
    logic       issue_b;
    logic       b_ok;
    cls_e       a_c;
    cls_e       b_c;

    assign a_c     = cls_e'(a_cls);
    assign b_c     = cls_e'(b_cls);
    assign stall   = stall_DCache || stall_div;
    assign ld_pend = (lu_cnt != 2'd0);
    assign blocked = !rstn || flush_BR || stall || !i_is_valid[1] || (state == ST_SERIAL);
    assign a_haz   = ld_pend && (ld_rd != 5'd0)
                  && ((a_rf_raddr1 == ld_rd) || (a_rf_raddr2 == ld_rd));
    assign issue_a = !blocked && !a_haz;

    issue_pair_chk u_pair_chk (
        .b_valid  (i_is_valid[0]),
        .a_rd     (a_rf_rd),
        .a_we     (a_rf_we),
        .a_cls    (a_c),
        .b_raddr1 (b_rf_raddr1),
        .b_raddr2 (b_rf_raddr2),
        .b_cls    (b_c),
        .ld_rd    (ld_rd),
        .ld_pend  (ld_pend),
        .b_ok     (b_ok)
    );

`ifdef DUAL_ISSUE_EN
    assign issue_b = issue_a && b_ok;
`else
    logic unused_b_ok;
    assign unused_b_ok = b_ok;
    assign issue_b     = 1'b0;
`endif

    assign o_usingNUM    = issue_b ? 2'd2 : (issue_a ? 2'd1 : 2'd0);
    assign o_serial_busy = rstn && (state == ST_SERIAL);

    // Slot B is younger, so its load destination is the one left pending.
    always_ff @(posedge clk) begin
        if (!rstn || flush_BR) begin
            ld_rd  <= 5'd0;
            lu_cnt <= 2'd0;
        end else if (!stall) begin
            if (issue_b && (b_c == CLS_LD) && b_rf_we && (b_rf_rd != 5'd0)) begin
                ld_rd  <= b_rf_rd;
                lu_cnt <= 2'(LU_BUBBLE);
            end else if (issue_a && (a_c == CLS_LD) && a_rf_we && (a_rf_rd != 5'd0)) begin
                ld_rd  <= a_rf_rd;
                lu_cnt <= 2'(LU_BUBBLE);
            end else if (lu_cnt != 2'd0) begin
                lu_cnt <= lu_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || flush_BR) begin
            state <= ST_IDLE;
        end else if (!stall) begin
            case (state)
                ST_IDLE:   if (issue_a && (a_c == CLS_PRIV)) state <= ST_SERIAL;
                ST_SERIAL: if (i_serial_done) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed scoreboard bench for issue_ctrl (LU_BUBBLE=1); follows DUAL_ISSUE_EN of the build.
module tb_issue_ctrl;
    import Public_Info::*;

`ifdef DUAL_ISSUE_EN
    localparam logic [1:0] P = 2'd2;
    localparam bit DUAL = 1'b1;
`else
    localparam logic [1:0] P = 2'd1;
    localparam bit DUAL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] i_is_valid;
    logic [4:0] a_rf_raddr1, a_rf_raddr2, b_rf_raddr1, b_rf_raddr2;
    logic [4:0] a_rf_rd, b_rf_rd;
    logic       a_rf_we, b_rf_we;
    logic [2:0] a_cls, b_cls;
    logic       flush_BR, stall_DCache, stall_div, i_serial_done;
    logic [1:0] o_usingNUM;
    logic       o_serial_busy;

    typedef struct {
        string      tag;
        logic [1:0] num;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    issue_ctrl #(.LU_BUBBLE(1)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_is_valid    (i_is_valid),
        .a_rf_raddr1   (a_rf_raddr1),
        .a_rf_raddr2   (a_rf_raddr2),
        .b_rf_raddr1   (b_rf_raddr1),
        .b_rf_raddr2   (b_rf_raddr2),
        .a_rf_rd       (a_rf_rd),
        .b_rf_rd       (b_rf_rd),
        .a_rf_we       (a_rf_we),
        .b_rf_we       (b_rf_we),
        .a_cls         (a_cls),
        .b_cls         (b_cls),
        .flush_BR      (flush_BR),
        .stall_DCache  (stall_DCache),
        .stall_div     (stall_div),
        .i_serial_done (i_serial_done),
        .o_usingNUM    (o_usingNUM),
        .o_serial_busy (o_serial_busy)
    );

    task automatic set_a(input cls_e c, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic we);
        a_cls = c; a_rf_rd = rd; a_rf_raddr1 = r1; a_rf_raddr2 = r2; a_rf_we = we;
    endtask

    task automatic set_b(input cls_e c, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic we);
        b_cls = c; b_rf_rd = rd; b_rf_raddr1 = r1; b_rf_raddr2 = r2; b_rf_we = we;
    endtask

    task automatic ctl(input logic [1:0] v, input logic fl, input logic sd,
                       input logic sv, input logic done);
        i_is_valid = v; flush_BR = fl; stall_DCache = sd; stall_div = sv; i_serial_done = done;
    endtask

    // Push expectation with the stimulus, compare mid-cycle, then advance one edge.
    task automatic step(input string tag, input logic [1:0] num, input logic busy);
        exp_t e;
        exp_t g;
        e.tag = tag; e.num = num; e.busy = busy;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        n_cmp++;
        assert (o_usingNUM === g.num) else begin
            n_bad++;
            $error("FAIL %s usingNUM observed=%0d expected=%0d", g.tag, o_usingNUM, g.num);
        end
        n_cmp++;
        assert (o_serial_busy === g.busy) else begin
            n_bad++;
            $error("FAIL %s serial_busy observed=%0d expected=%0d", g.tag, o_serial_busy, g.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pair_ok();
        set_a(CLS_ALU, 5'd4, 5'd1, 5'd2, 1'b1);
        set_b(CLS_ALU, 5'd5, 5'd3, 5'd6, 1'b1);
    endtask

    initial begin
        rstn = 1'b0;
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        pair_ok();
        step("reset0", 2'd0, 1'b0);
        step("reset1", 2'd0, 1'b0);
        rstn = 1'b1;

        // Basic pairing and RAW between slots
        pair_ok();                                   step("pair_free", P, 1'b0);
        set_b(CLS_ALU, 5'd7, 5'd4, 5'd0, 1'b1);      step("raw_ab", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd0, 5'd1, 5'd2, 1'b1);      step("raw_rd0", P, 1'b0);
        pair_ok();
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("valid10", 2'd1, 1'b0);
        ctl(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);          step("valid00", 2'd0, 1'b0);
        ctl(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);          step("valid01", 2'd0, 1'b0);
        ctl(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);          step("flush_blk", 2'd0, 1'b0);
        ctl(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);          step("div_blk", 2'd0, 1'b0);

        // Load-use bubble
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);       step("ld_r8", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd8, 5'd2, 1'b1);      step("lu_bubble", 2'd0, 1'b0);
                                                     step("lu_after", 2'd1, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);       step("ld_r8b", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd2, 5'd8, 1'b1);
        ctl(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);          step("lu_stall0", 2'd0, 1'b0);
                                                     step("lu_stall1", 2'd0, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("lu_frozen", 2'd0, 1'b0);
                                                     step("lu_resume", 2'd1, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);       step("ld_r8c", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd10, 5'd1, 5'd2, 1'b1);
        set_b(CLS_ALU, 5'd11, 5'd8, 5'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("b_reads_ld", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd8, 5'd2, 1'b1);      step("ld_expired", P, 1'b0);
        set_a(CLS_ALU, 5'd1, 5'd2, 5'd3, 1'b1);
        set_b(CLS_LD, 5'd13, 5'd2, 5'd0, 1'b1);      step("b_ld_r13", P, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd13, 5'd2, 1'b1);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("b_ld_use", DUAL ? 2'd0 : 2'd1, 1'b0);
                                                     step("b_ld_after", 2'd1, 1'b0);
        set_a(CLS_LD, 5'd0, 5'd1, 5'd0, 1'b1);       step("ld_r0", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd0, 5'd0, 1'b1);      step("ld_r0_use", 2'd1, 1'b0);

        // Class pairing rules
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        set_a(CLS_LD, 5'd14, 5'd1, 5'd0, 1'b1);
        set_b(CLS_ST, 5'd0, 5'd2, 5'd3, 1'b0);       step("ld_st", 2'd1, 1'b0);
        set_a(CLS_MULDIV, 5'd4, 5'd1, 5'd2, 1'b1);
        set_b(CLS_MULDIV, 5'd5, 5'd3, 5'd6, 1'b1);   step("mul_mul", 2'd1, 1'b0);
        set_a(CLS_BR, 5'd0, 5'd1, 5'd2, 1'b0);
        set_b(CLS_ALU, 5'd5, 5'd3, 5'd6, 1'b1);      step("a_br", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd4, 5'd1, 5'd2, 1'b1);
        set_b(CLS_PRIV, 5'd0, 5'd3, 5'd6, 1'b0);     step("b_priv", 2'd1, 1'b0);
        set_a(CLS_ST, 5'd0, 5'd1, 5'd2, 1'b0);
        set_b(CLS_ALU, 5'd5, 5'd3, 5'd6, 1'b1);      step("st_alu", P, 1'b0);

        // Serialization
        set_a(CLS_PRIV, 5'd0, 5'd1, 5'd2, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("priv", 2'd1, 1'b0);
        pair_ok();
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("serial0", 2'd0, 1'b1);
                                                     step("serial1", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);          step("serial_done", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("serial_exit", P, 1'b0);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);          step("done_idle", P, 1'b0);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("done_ignored", P, 1'b0);
        set_a(CLS_PRIV, 5'd0, 5'd1, 5'd2, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b1);          step("priv_done", 2'd1, 1'b0);
        pair_ok();
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("priv_done_ser", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);          step("serial_stall", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("serial_frozen", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b1);          step("serial_done2", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("serial_exit2", P, 1'b0);

        // Flush recovery
        set_a(CLS_PRIV, 5'd0, 5'd1, 5'd2, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("priv_f", 2'd1, 1'b0);
        pair_ok();
        ctl(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);          step("serial_flush", 2'd0, 1'b1);
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);          step("flush_exit", P, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("ld_f", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd8, 5'd2, 1'b1);
        ctl(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);          step("ld_flush", 2'd0, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("flush_clr_cnt", 2'd1, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);       step("ld_fs", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd8, 5'd2, 1'b1);
        ctl(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);          step("flush_stall", 2'd0, 1'b0);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("flush_over_stall", 2'd1, 1'b0);

        // Reset mid-serial and mid-bubble
        set_a(CLS_PRIV, 5'd0, 5'd1, 5'd2, 1'b0);     step("priv_r", 2'd1, 1'b0);
        pair_ok();
        ctl(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;                                 step("rst_serial", 2'd0, 1'b0);
        rstn = 1'b1;                                 step("rst_serial_exit", P, 1'b0);
        set_a(CLS_LD, 5'd8, 5'd1, 5'd0, 1'b1);
        ctl(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);          step("ld_r", 2'd1, 1'b0);
        set_a(CLS_ALU, 5'd9, 5'd8, 5'd2, 1'b1);
        rstn = 1'b0;                                 step("rst_bubble", 2'd0, 1'b0);
        rstn = 1'b1;                                 step("rst_clr_cnt", 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
